// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants for the BCD up/down counter: digit limits and the
// seven-segment decode used for every display digit.
package bcd_updown_counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Patterns are gfedcba, active-high. Codes 10..15 cannot be stored, so they blank.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic active_low);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = SEG_BLANK;
    endcase
    return active_low ? ~p : p;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit_cell.sv
// One BCD digit: load with clamp to 9, and up/down step gated by the
// carry/borrow chain coming from the lower digits.
module bcd_digit_cell
  import bcd_updown_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       up_down,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       clamped
);

  assign clamped = (load_val > BCD_MAX);

  // cin means every lower digit sits at the limit for the current direction.
  assign cout = cin & (up_down ? (digit == BCD_MAX) : (digit == BCD_MIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= clamped ? BCD_MAX : load_val;
    end else if (step && cin) begin
      if (up_down)
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      else
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with tick prescaler, parallel load,
// wrap/saturate limit handling and per-digit seven-segment outputs.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 50_000_000,
  parameter int SATURATE       = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_next;
  logic [DIGITS:0] carry;
  logic [DIGITS-1:0] clamp;
  logic            at_limit;
  logic            count_try;
  logic            step;

  always_comb begin
    presc_next = presc + 1'b1;
    if (load || presc == PRESC_LAST)
      presc_next = '0;
  end

  assign carry[0]  = 1'b1;
  assign at_limit  = carry[DIGITS];
  assign count_try = tick & enable & ~load;
  // In saturate mode the step is dropped at the limit but still reported as wrap.
  assign step      = count_try & ~((SATURATE != 0) & at_limit);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (data_in[4*k +: 4]),
      .step     (step),
      .up_down  (up_down),
      .cin      (carry[k]),
      .digit    (bcd[4*k +: 4]),
      .cout     (carry[k+1]),
      .clamped  (clamp[k])
    );
  end

  // tick is registered so it reads as the cycle in which presc == TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      presc    <= presc_next;
      tick     <= (presc_next == PRESC_LAST);
      wrap     <= count_try & at_limit;
      load_err <= load & (|clamp);
    end
  end

  always_comb begin
    seg = '0;
    for (int k = 0; k < DIGITS; k++)
      seg[7*k +: 7] = seg_decode(bcd[4*k +: 4], SEG_ACTIVE_LOW != 0);
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a wrapping and a saturating
// instance share stimulus, DIGITS=4, TICK_DIV=4, active-low segments.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;

  logic [15:0] bcd, sat_bcd;
  logic [27:0] seg, sat_seg;
  logic        tick, sat_tick, wrap, sat_wrap, load_err, sat_load_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ticks;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S9 = 7'b0010000;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .TICK_DIV(4), .SATURATE(0), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
    .data_in(data_in), .bcd(bcd), .seg(seg), .tick(tick), .wrap(wrap),
    .load_err(load_err)
  );

  bcd_updown_counter #(.DIGITS(4), .TICK_DIV(4), .SATURATE(1), .SEG_ACTIVE_LOW(1)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
    .data_in(data_in), .bcd(sat_bcd), .seg(sat_seg), .tick(sat_tick), .wrap(sat_wrap),
    .load_err(sat_load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    data_in = v;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    // Reset state and first tick after release
    step(2);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_seg", seg, {4{S0}});
    check("rst_tick", tick, 1'b0);
    check("rst_wrap", wrap, 1'b0);
    check("rst_lerr", load_err, 1'b0);
    rst = 1'b0;
    step(2);
    check("tick_early", tick, 1'b0);
    step(1);
    check("tick_first", tick, 1'b1);
    step(1);
    check("tick_width", tick, 1'b0);

    // Up count with carry ripple
    enable = 1'b1;
    up_down = 1'b1;
    do_load(16'h0998);
    check("ld_0998", bcd, 16'h0998);
    check("ld_noerr", load_err, 1'b0);
    step(3);
    check("up_tick", tick, 1'b1);
    check("up_pre", bcd, 16'h0998);
    step(1);
    check("up_1", bcd, 16'h0999);
    step(4);
    check("up_2", bcd, 16'h1000);
    check("up_seg", seg, {S1, S0, S0, S0});

    // Wrap up, then down; saturating instance holds
    do_load(16'h9999);
    step(4);
    check("wrap_up_bcd", bcd, 16'h0000);
    check("wrap_up_pulse", wrap, 1'b1);
    check("sat_up_bcd", sat_bcd, 16'h9999);
    check("sat_up_pulse", sat_wrap, 1'b1);
    up_down = 1'b0;
    step(1);
    check("wrap_up_width", wrap, 1'b0);
    step(3);
    check("wrap_dn_bcd", bcd, 16'h9999);
    check("wrap_dn_pulse", wrap, 1'b1);
    check("sat_dn_bcd", sat_bcd, 16'h9998);
    check("sat_dn_nowrap", sat_wrap, 1'b0);

    // Saturate at zero for three ticks
    do_load(16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(3);
      check("sat_gap", sat_wrap, 1'b0);
      step(1);
      check("sat_hold", sat_bcd, 16'h0000);
      check("sat_pulse", sat_wrap, 1'b1);
      check("dn_wrapmode", bcd, (i == 0) ? 16'h9999 : (i == 1) ? 16'h9998 : 16'h9997);
    end

    // Load coincident with tick: clamp, error pulse, no count
    step(3);
    check("prio_tick", tick, 1'b1);
    do_load(16'h12F4);
    check("clamp_bcd", bcd, 16'h1294);
    check("clamp_err", load_err, 1'b1);
    check("clamp_nowrap", wrap, 1'b0);
    step(1);
    check("clamp_err_w", load_err, 1'b0);
    step(1);
    check("ld_tick_no", tick, 1'b0);
    step(1);
    check("ld_tick_yes", tick, 1'b1);
    step(1);
    check("ld_count", bcd, 16'h1293);

    // Enable low: count frozen, prescaler keeps running
    enable = 1'b0;
    n_ticks = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (tick) n_ticks++;
    end
    check("en_ticks", n_ticks, 20);
    check("en_hold", bcd, 16'h1293);
    check("en_seg", seg, {S1, S2, S9, S3});

    // Asynchronous reset mid-count
    enable = 1'b1;
    up_down = 1'b1;
    do_load(16'h0347);
    check("ld_0347", bcd, 16'h0347);
    step(3);
    check("pre_rst_tick", tick, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_bcd", bcd, 16'h0000);
    check("arst_seg", seg, {4{S0}});
    check("arst_tick", tick, 1'b0);
    check("arst_wrap", wrap, 1'b0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
